// File: rtl/mcpu_pkg.sv
// ============================================================================
// Module      : mcpu_pkg
// Description : Shared constants and types for the MCPU instruction fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mcpu_pkg;

    localparam int WORD_SIZE  = 8;
    localparam int ADDR_WIDTH = 8;
    localparam int FIFO_DEPTH = 4;
    localparam logic [ADDR_WIDTH-1:0] RESET_ADDR = '0;

    typedef logic [WORD_SIZE-1:0]  instr_t;
    typedef logic [ADDR_WIDTH-1:0] addr_t;

    typedef struct packed {
        instr_t instr;
        addr_t  pc;
    } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/mcpu_instr_fetch_if.sv
// ============================================================================
// Module      : mcpu_instr_fetch_if
// Description : RAM-side address/data and decoder-side valid/ready bundle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mcpu_instr_fetch_if;
    import mcpu_pkg::*;

    logic   fetch_en;
    addr_t  instraddr;
    instr_t instrrd;
    logic   redirect;
    addr_t  redirect_addr;
    instr_t instr_out;
    addr_t  instr_pc;
    logic   instr_valid;
    logic   instr_ready;

    modport master (
        input  fetch_en, instrrd, redirect, redirect_addr, instr_ready,
        output instraddr, instr_out, instr_pc, instr_valid
    );

    modport slave (
        output fetch_en, instrrd, redirect, redirect_addr, instr_ready,
        input  instraddr, instr_out, instr_pc, instr_valid
    );

endinterface

`default_nettype wire

// File: rtl/mcpu_fetch_fifo.sv
// ============================================================================
// Module      : mcpu_fetch_fifo
// Description : Register FIFO of fetch entries; synchronous write, async read.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mcpu_fetch_fifo
    import mcpu_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH
) (
    input  wire logic                   clk,
    input  wire logic                   reset,
    input  wire logic                   push,
    input  wire logic                   pop,
    input  wire logic                   flush,
    input  wire fetch_entry_t           wr_entry,
    output fetch_entry_t                rd_entry,
    output logic [$clog2(DEPTH):0]      count
);

    localparam int c_PTR_W = $clog2(DEPTH);

    fetch_entry_t             r_mem [DEPTH];
    logic [c_PTR_W-1:0]       r_rd_ptr;
    logic [c_PTR_W-1:0]       r_wr_ptr;
    logic [c_PTR_W:0]         r_count;

    // Storage is cleared on reset so the head reads as zero until the first push.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_mem[r_wr_ptr] <= wr_entry;
                r_wr_ptr        <= r_wr_ptr + c_PTR_W'(1);
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + (c_PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (c_PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign rd_entry = r_mem[r_rd_ptr];
    assign count    = r_count;

endmodule

`default_nettype wire

// File: rtl/mcpu_instr_fetch.sv
// ============================================================================
// Module      : mcpu_instr_fetch
// Description : PC register, prefetch control and redirect handling.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mcpu_instr_fetch
    import mcpu_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH
) (
    input  wire logic              clk,
    input  wire logic              reset,
    mcpu_instr_fetch_if.master     bus
);

    localparam int                c_CNT_W     = $clog2(DEPTH) + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);

    addr_t              r_pc;
    logic [c_CNT_W-1:0] w_count;
    logic               w_pop;
    logic               w_push;
    fetch_entry_t       w_tail;
    fetch_entry_t       w_head;

    assign w_pop  = bus.instr_valid && bus.instr_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_push = bus.fetch_en && ((w_count < c_DEPTH_CNT) || w_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc <= RESET_ADDR;
        end else if (bus.redirect) begin
            r_pc <= bus.redirect_addr;
        end else if (w_push) begin
            r_pc <= r_pc + addr_t'(1);
        end
    end

    assign w_tail = '{instr: bus.instrrd, pc: r_pc};

    mcpu_fetch_fifo #(
        .DEPTH    (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (w_push && !bus.redirect),
        .pop      (w_pop && !bus.redirect),
        .flush    (bus.redirect),
        .wr_entry (w_tail),
        .rd_entry (w_head),
        .count    (w_count)
    );

    assign bus.instraddr   = r_pc;
    assign bus.instr_out   = w_head.instr;
    assign bus.instr_pc    = w_head.pc;
    assign bus.instr_valid = (w_count != '0);

endmodule

`default_nettype wire

// File: tb/tb_mcpu_instr_fetch.sv
// ============================================================================
// Module      : tb_mcpu_instr_fetch
// Description : Scoreboard bench for the fetch stage against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mcpu_instr_fetch;

    logic clk;
    logic reset;
    logic [7:0] mem [256];

    mcpu_instr_fetch_if bus();

    mcpu_instr_fetch dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Combinational instruction memory standing in for the RAM controller.
    assign bus.instrrd = mem[bus.instraddr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;

    logic [15:0] exp_q[$];
    int          mcount = 0;
    logic [7:0]  mpc    = 8'd0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: occupancy count, PC and queue of expected {instr, pc}.
    always @(posedge clk or posedge reset) begin
        bit m_pop, m_push;
        if (reset) begin
            exp_q.delete();
            mcount = 0;
            mpc    = 8'd0;
        end else if (bus.redirect) begin
            exp_q.delete();
            mcount = 0;
            mpc    = bus.redirect_addr;
        end else begin
            m_pop  = (mcount > 0) && bus.instr_ready;
            m_push = bus.fetch_en && ((mcount < 4) || m_pop);
            if (m_push) begin
                exp_q.push_back({mem[mpc], mpc});
                mpc = mpc + 8'd1;
            end
            mcount = mcount + int'(m_push) - int'(m_pop);
        end
    end

    // Monitor: compares every completed handshake against the scoreboard.
    always @(negedge clk) begin
        logic [15:0] e;
        if (!reset) begin
            chk("instraddr", bus.instraddr, mpc);
            chk("instr_valid", bus.instr_valid, mcount > 0);
            if (bus.instr_valid && bus.instr_ready && !bus.redirect) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errs++;
                    $display("FAIL handshake: got pc %0d expected no valid entry", bus.instr_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_instr", bus.instr_out, e[15:8]);
                    chk("sb_pc", bus.instr_pc, e[7:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        #2 reset = 1'b1;
        #1;
        chk("rst_valid", bus.instr_valid, 0);
        chk("rst_addr", bus.instraddr, 0);
        #2 reset = 1'b0;
    endtask

    initial begin
        reset             = 1'b1;
        bus.fetch_en      = 1'b0;
        bus.instr_ready   = 1'b0;
        bus.redirect      = 1'b0;
        bus.redirect_addr = 8'd0;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[0] = 8'd51; mem[1] = 8'd2; mem[2] = 8'd51; mem[3] = 8'd16;

        #3;
        chk("reset_valid", bus.instr_valid, 0);
        chk("reset_out", bus.instr_out, 0);
        chk("reset_pc", bus.instr_pc, 0);
        chk("reset_addr", bus.instraddr, 0);
        bus.fetch_en    = 1'b1;
        bus.instr_ready = 1'b1;
        #4 reset = 1'b0;

        // Stream
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stream_out", bus.instr_out, mem[i]);
            chk("stream_pc", bus.instr_pc, i);
        end

        // Backpressure from a fresh start
        bus.instr_ready = 1'b0;
        pulse_reset();
        repeat (8) tick();
        chk("bp_addr", bus.instraddr, 4);
        chk("bp_out", bus.instr_out, 51);
        chk("bp_pc", bus.instr_pc, 0);
        bus.instr_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("bp_drain_pc", bus.instr_pc, i);
            chk("bp_drain_out", bus.instr_out, mem[i]);
        end

        // Redirect with three buffered entries
        bus.fetch_en = 1'b0; bus.redirect = 1'b1; bus.redirect_addr = 8'd100;
        tick();
        bus.redirect = 1'b0; bus.fetch_en = 1'b1; bus.instr_ready = 1'b0;
        repeat (3) tick();
        bus.redirect = 1'b1; bus.redirect_addr = 8'd8;
        tick();
        bus.redirect = 1'b0;
        chk("redir_bubble", bus.instr_valid, 0);
        tick();
        chk("redir_valid", bus.instr_valid, 1);
        chk("redir_out", bus.instr_out, mem[8]);
        chk("redir_pc", bus.instr_pc, 8);

        // Address wrap
        bus.instr_ready = 1'b1; bus.redirect = 1'b1; bus.redirect_addr = 8'd255;
        tick();
        bus.redirect = 1'b0;
        chk("wrap_bubble", bus.instr_valid, 0);
        chk("wrap_addr0", bus.instraddr, 255);
        tick();
        chk("wrap_pc255", bus.instr_pc, 255);
        chk("wrap_addr1", bus.instraddr, 0);
        tick();
        chk("wrap_pc0", bus.instr_pc, 0);
        tick();
        chk("wrap_pc1", bus.instr_pc, 1);

        // Redirect colliding with a handshake on a full FIFO
        bus.instr_ready = 1'b0;
        repeat (5) tick();
        chk("coll_full_valid", bus.instr_valid, 1);
        bus.instr_ready = 1'b1; bus.redirect = 1'b1; bus.redirect_addr = 8'd20;
        tick();
        bus.redirect = 1'b0;
        chk("coll_empty", bus.instr_valid, 0);
        chk("coll_addr", bus.instraddr, 20);
        tick();
        chk("coll_pc", bus.instr_pc, 20);
        chk("coll_out", bus.instr_out, mem[20]);

        // Mid-stream reset
        repeat (3) tick();
        pulse_reset();
        tick();
        chk("mrst_pc", bus.instr_pc, 0);
        chk("mrst_out", bus.instr_out, 51);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            bus.fetch_en      = ($urandom_range(0, 3) != 0);
            bus.instr_ready   = ($urandom_range(0, 2) != 0);
            bus.redirect      = ($urandom_range(0, 15) == 0);
            bus.redirect_addr = 8'($urandom);
            tick();
        end
        bus.redirect = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

`default_nettype wire
